// File: rtl/l2_mem_pkg.sv
// Shared types and helpers for the L2 memory bank array.
package l2_mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    DONE
  } init_state_e;

  // Region decode result: SCM flag plus the index local to the selected region.
  typedef struct packed {
    logic        scm;
    logic [31:0] idx;
  } region_t;

  // Only zero or one output pipeline stage is supported.
  function automatic bit rd_pipe_legal(int unsigned rd_pipe);
    return rd_pipe <= 1;
  endfunction

  function automatic logic in_scm(logic [31:0] addr, int unsigned scm_words);
    return addr < scm_words;
  endfunction

  // Low words live in SCM; the remainder is rebased to index 0 of the SRAM.
  function automatic region_t region_of(logic [31:0] addr, int unsigned scm_words);
    region_t r;
    r.scm = in_scm(addr, scm_words);
    r.idx = r.scm ? addr : addr - scm_words;
    return r;
  endfunction

endpackage

// File: rtl/l2_mem_region_bank.sv
// One bank: SCM and SRAM arrays, byte-enable writes, registered read,
// optional output pipeline stage and matching rvalid pipeline.
module l2_mem_region_bank
  import l2_mem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 14,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned SCM_WORDS  = 512,
  parameter int unsigned RD_PIPE    = 0,
  localparam int unsigned BE_WIDTH  = DATA_WIDTH / 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  test_mode_i,
  input  logic                  en_i,
  input  logic                  we_i,
  input  logic [BE_WIDTH-1:0]   be_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic                  rvalid_o,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  localparam int unsigned BANK_WORDS = 2 ** ADDR_WIDTH;
  localparam int unsigned SRAM_WORDS = BANK_WORDS - SCM_WORDS;
  localparam int unsigned SCM_IW     = (SCM_WORDS > 1) ? $clog2(SCM_WORDS) : 1;
  localparam int unsigned SRAM_IW    = (SRAM_WORDS > 1) ? $clog2(SRAM_WORDS) : 1;

  logic [DATA_WIDTH-1:0] scm_mem  [SCM_WORDS];
  logic [DATA_WIDTH-1:0] sram_mem [SRAM_WORDS];

  region_t               rg;
  logic [SCM_IW-1:0]     scm_idx;
  logic [SRAM_IW-1:0]    sram_idx;
  logic                  rd_en;
  logic                  rvalid_q;
  logic [DATA_WIDTH-1:0] rdata_q;

  // Scan enable has no effect on the behavioural arrays; upper index bits are
  // never needed because each region is smaller than the bank.
  logic unused_ok;
  assign unused_ok = ^{test_mode_i, rg};

  // Decode the access into exactly one region and its local index.
  always_comb begin
    rg       = region_of(32'(addr_i), SCM_WORDS);
    scm_idx  = rg.idx[SCM_IW-1:0];
    sram_idx = rg.idx[SRAM_IW-1:0];
    rd_en    = en_i & ~we_i;
  end

  // Byte-enabled write into whichever region the address selects.
  always_ff @(posedge clk_i) begin
    if (en_i && we_i) begin
      for (int unsigned i = 0; i < BE_WIDTH; i++) begin
        if (be_i[i]) begin
          if (rg.scm) scm_mem[scm_idx][8*i +: 8] <= wdata_i[8*i +: 8];
          else        sram_mem[sram_idx][8*i +: 8] <= wdata_i[8*i +: 8];
        end
      end
    end
  end

  // Registered read; data holds until the next read.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= rd_en;
      if (rd_en) rdata_q <= rg.scm ? scm_mem[scm_idx] : sram_mem[sram_idx];
    end
  end

  if (RD_PIPE != 0) begin : g_rd_pipe
    logic                  rvalid_p;
    logic [DATA_WIDTH-1:0] rdata_p;

    // Extra output stage; only captures on valid so data still holds.
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        rvalid_p <= 1'b0;
        rdata_p  <= '0;
      end else begin
        rvalid_p <= rvalid_q;
        if (rvalid_q) rdata_p <= rdata_q;
      end
    end

    assign rvalid_o = rvalid_p;
    assign rdata_o  = rdata_p;
  end else begin : g_no_rd_pipe
    assign rvalid_o = rvalid_q;
    assign rdata_o  = rdata_q;
  end

endmodule

// File: rtl/l2_mem_bank_array.sv
// Parametrised array of independent SCM/SRAM banks with a shared init
// sequencer that fills every bank with a constant.
module l2_mem_bank_array
  import l2_mem_pkg::*;
#(
  parameter int unsigned           NB_BANKS   = 4,
  parameter int unsigned           ADDR_WIDTH = 14,
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           SCM_WORDS  = 512,
  parameter int unsigned           RD_PIPE    = 0,
  parameter bit                    AUTO_INIT  = 1'b1,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0,
  localparam int unsigned          BE_WIDTH   = DATA_WIDTH / 8
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic                                 test_mode_i,
  input  logic                                 init_req_i,
  output logic                                 init_busy_o,
  output logic                                 init_done_o,
  input  logic [NB_BANKS-1:0]                  req_i,
  input  logic [NB_BANKS-1:0]                  we_i,
  input  logic [NB_BANKS-1:0][BE_WIDTH-1:0]    be_i,
  input  logic [NB_BANKS-1:0][ADDR_WIDTH-1:0]  addr_i,
  input  logic [NB_BANKS-1:0][DATA_WIDTH-1:0]  wdata_i,
  output logic [NB_BANKS-1:0]                  gnt_o,
  output logic [NB_BANKS-1:0]                  rvalid_o,
  output logic [NB_BANKS-1:0][DATA_WIDTH-1:0]  rdata_o,
  output logic [NB_BANKS-1:0]                  scm_sel_o
);

  // Out-of-range RD_PIPE values fall back to a single output stage.
  localparam int unsigned RD_STAGES = rd_pipe_legal(RD_PIPE) ? RD_PIPE : 1;

  init_state_e           state;
  logic [ADDR_WIDTH-1:0] fill_cnt;
  logic                  busy_q;
  logic                  done_q;

  logic [NB_BANKS-1:0]                 bank_en;
  logic [NB_BANKS-1:0]                 bank_we;
  logic [NB_BANKS-1:0][BE_WIDTH-1:0]   bank_be;
  logic [NB_BANKS-1:0][ADDR_WIDTH-1:0] bank_addr;
  logic [NB_BANKS-1:0][DATA_WIDTH-1:0] bank_wdata;

  // Init sequencer: one word per cycle across all banks, single pass.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= AUTO_INIT ? FILL : IDLE;
      fill_cnt <= '0;
      busy_q   <= AUTO_INIT;
      done_q   <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (init_req_i) begin
            state    <= FILL;
            fill_cnt <= '0;
            busy_q   <= 1'b1;
            done_q   <= 1'b0;
          end
        end
        FILL: begin
          fill_cnt <= fill_cnt + ADDR_WIDTH'(1);
          if (fill_cnt == '1) begin
            state  <= DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
      endcase
    end
  end

  assign init_busy_o = busy_q;
  assign init_done_o = done_q;
  assign gnt_o       = req_i & {NB_BANKS{~busy_q}};

  // Fill owns every bank while busy; otherwise user requests pass straight through.
  always_comb begin
    for (int unsigned b = 0; b < NB_BANKS; b++) begin
      bank_en[b]    = busy_q | req_i[b];
      bank_we[b]    = busy_q | we_i[b];
      bank_be[b]    = busy_q ? '1 : be_i[b];
      bank_addr[b]  = busy_q ? fill_cnt : addr_i[b];
      bank_wdata[b] = busy_q ? INIT_VALUE : wdata_i[b];
      scm_sel_o[b]  = gnt_o[b] & in_scm(32'(addr_i[b]), SCM_WORDS);
    end
  end

  for (genvar g = 0; g < NB_BANKS; g++) begin : g_bank
    l2_mem_region_bank #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH),
      .SCM_WORDS  (SCM_WORDS),
      .RD_PIPE    (RD_STAGES)
    ) u_bank (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .test_mode_i (test_mode_i),
      .en_i        (bank_en[g]),
      .we_i        (bank_we[g]),
      .be_i        (bank_be[g]),
      .addr_i      (bank_addr[g]),
      .wdata_i     (bank_wdata[g]),
      .rvalid_o    (rvalid_o[g]),
      .rdata_o     (rdata_o[g])
    );
  end

endmodule
